// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Word-read bus between the instruction fetch stage and the
//               memory controller.
//                 mem_req  - read request level, held until mem_done
//                 mem_addr - word address of the read, bits [1:0] are zero
//                 mem_done - one-cycle pulse, mem_data valid in that cycle
//                 mem_data - returned instruction word
//               master : fetch stage side (drives mem_req/mem_addr)
//               slave  : memory controller side (drives mem_done/mem_data)
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_done,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_done,
        output mem_data
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction fetch stage with a direct-mapped, one-word-per-
//               line instruction cache. A hit presents the instruction on the
//               next edge; a miss issues a word read on the memory bus and
//               stalls the PC register until the line is filled.
// Ports       : clk_in    - clock
//               rst_in    - synchronous active-high reset
//               rdy_in    - global ready, low freezes every register
//               pc_in     - fetch PC (held by upstream while stall_req = 1)
//               jmp_tak   - redirect/flush from execute
//               stall_in  - downstream (ID) stall
//               stall_req - combinational request to hold pc_in
//               if_valid  - if_pc/if_inst carry a valid instruction
//               if_pc     - word-aligned PC of presented instruction
//               if_inst   - presented instruction word
//               mem       - memory read bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int IDX_W = 6
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    input  wire logic        rdy_in,
    input  wire logic [31:0] pc_in,
    input  wire logic        jmp_tak,
    input  wire logic        stall_in,
    output logic             stall_req,
    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    if_stage_if.master       mem
);

    localparam int c_DEPTH = 1 << IDX_W;
    localparam int c_TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_if_valid;
    logic [31:0]         r_if_pc;
    logic [31:0]         r_if_inst;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;
    // Set when a redirect arrives while a miss is outstanding: the fill still
    // completes into the cache but must not be presented downstream.
    logic                r_discard;

    // Valid bits are a flat vector so reset can clear every line at once;
    // tag and data arrays carry no reset and are qualified by r_valid.
    logic [c_DEPTH-1:0]  r_valid;
    logic [c_TAG_W-1:0]  r_tag  [c_DEPTH];
    logic [31:0]         r_data [c_DEPTH];

    // ------------------------------------------------------------------------
    // Address split and hit detection
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]    w_idx;
    logic [c_TAG_W-1:0]  w_tag;
    logic                w_hit;
    logic [IDX_W-1:0]    w_fill_idx;
    logic [c_TAG_W-1:0]  w_fill_tag;
    logic                w_fill;
    logic [31:0]         w_pc_word;

    assign w_idx      = pc_in[IDX_W+1:2];
    assign w_tag      = pc_in[31:IDX_W+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pc_word  = {pc_in[31:2], 2'b00};

    // The fill location comes from the registered request address, not from
    // pc_in, so a redirected pc_in cannot steer the write to the wrong line.
    assign w_fill_idx = r_mem_addr[IDX_W+1:2];
    assign w_fill_tag = r_mem_addr[31:IDX_W+2];
    assign w_fill     = rdy_in && !rst_in && (r_state == S_WAIT) && mem.mem_done;

    // Byte offset within the word is irrelevant to a word-granular fetch.
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^pc_in[1:0];

    // ------------------------------------------------------------------------
    // Stall request: a miss in IDLE stalls in the detect cycle itself, unless
    // a redirect is discarding the current PC anyway.
    // ------------------------------------------------------------------------
    assign stall_req = stall_in
                     | (r_state == S_WAIT)
                     | ((r_state == S_IDLE) & !w_hit & !jmp_tak);

    // ------------------------------------------------------------------------
    // Control state machine and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'h0;
            r_if_pc    <= 32'h0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
            r_discard  <= 1'b0;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (jmp_tak) begin
                        r_if_valid <= 1'b0;
                    end else if (stall_in) begin
                        // Downstream is stalled: hold the presented instruction.
                        r_if_valid <= r_if_valid;
                    end else if (w_hit) begin
                        r_if_inst  <= r_data[w_idx];
                        r_if_pc    <= w_pc_word;
                        r_if_valid <= 1'b1;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_pc_word;
                        r_if_valid <= 1'b0;
                        r_discard  <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (jmp_tak) begin
                        r_discard  <= 1'b1;
                        r_if_valid <= 1'b0;
                    end
                    if (mem.mem_done) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_mem_req           <= 1'b0;
                        // A fill dropped here by stall_in is not lost: pc_in is
                        // held, so it is re-presented as a hit afterwards.
                        if (!r_discard && !jmp_tak && !stall_in) begin
                            r_if_inst  <= mem.mem_data;
                            r_if_pc    <= r_mem_addr;
                            r_if_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Tag and data arrays: written on every completed fill, whether or not
    // the word is presented, so the line is correct for its address.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem.mem_data;
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign if_valid     = r_if_valid;
    assign if_pc        = r_if_pc;
    assign if_inst      = r_if_inst;
    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction fetch stage with a direct-mapped instruction cache. It sits directly downstream of the PC register: it takes the fetch PC, looks it up in the cache, and on a miss issues a word read to the memory controller. It presents the fetched instruction to the IF/ID boundary, and asserts `stall_req` back to the PC register whenever it cannot accept a new PC.

## Interface

Parameters:
- `IDX_W`, default 6: cache index width; the cache has 2^IDX_W one-word lines. Tag width is 30-IDX_W.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global ready; when low, every register holds its value.
- `pc_in` in 32: fetch PC from the PC register. Must be held stable while `stall_req`=1.
- `jmp_tak` in 1: redirect/flush from the execute stage.
- `stall_in` in 1: downstream (ID) stall.
- `stall_req` out 1: combinational. Upstream must hold `pc_in`.
- `if_valid` out 1: `if_inst`/`if_pc` carry a valid instruction.
- `if_pc` out 32: PC of the presented instruction.
- `if_inst` out 32: instruction word.
- `mem_req` out 1: memory read request, level, registered.
- `mem_addr` out 32: word address, registered; bits [1:0] always 0.
- `mem_done` in 1: one-cycle pulse; `mem_data` valid this cycle.
- `mem_data` in 32: returned word.

## Operation

- **Address split:** `pc_in[1:0]` ignored. Index = `pc_in[IDX_W+1:2]`. Tag = `pc_in[31:IDX_W+2]`. Storage is valid[2^IDX_W], tag, and data arrays.
- **hit:** combinational, `valid[idx] && tag[idx]==pc tag`.
- **States:**
  - IDLE:
    - `jmp_tak`: next `if_valid`=0, stay IDLE.
    - Else `stall_in`: hold outputs.
    - Else hit: `if_inst`<=data[idx], `if_pc`<=`{pc_in[31:2],2'b0}`, `if_valid`<=1.
    - Else miss: `mem_req`<=1, `mem_addr`<=`{pc_in[31:2],2'b0}`, `if_valid`<=0, `discard`<=0, go WAIT.
  - WAIT:
    - `jmp_tak` sets `discard`<=1 and forces `if_valid`<=0. The memory transaction is not cancelled.
    - On `mem_done`: write data/tag/valid at the index of `mem_addr`, and `mem_req`<=0.
      - If neither `discard` nor `jmp_tak` is set, and `stall_in`=0: `if_inst`<=`mem_data`, `if_pc`<=`mem_addr`, `if_valid`<=1.
      - Return to IDLE.
- **`stall_req`** = `stall_in` | (state==WAIT) | (state==IDLE & !hit & !`jmp_tak`).
- **Cache write is unconditional on `mem_done`:** the data is correct for its address even if discarded or stalled. An instruction dropped because of `stall_in` is re-presented as a hit after the stall, since the PC is held.
- **Eviction:** aliasing index overwrites the line. There is no write-invalidate; self-modifying code is unsupported.
- **Reset values:** state=IDLE, all valid bits 0, `if_valid`=0, `if_inst`=0, `if_pc`=0, `mem_req`=0, `mem_addr`=0, `discard`=0.
- **`rdy_in`=0:** no state, output, or cache change. `mem_done` arriving while `rdy_in`=0 is undefined; the memory controller is gated by the same signal.

## Timing

- **Hit:** `pc_in` sampled at edge N, `if_*` valid after edge N. Throughput is 1 instruction/cycle on consecutive hits.
- **Miss:**
  - `mem_req` is high from the edge after the miss is detected.
  - `stall_req` is high from the miss-detect cycle through the `mem_done` cycle.
  - `if_valid` rises on the edge sampling `mem_done`.
  - Penalty = memory latency + 1 cycle.
- **`mem_req`:** drops on the same edge that samples `mem_done`. `mem_addr` is stable throughout WAIT.
- **`jmp_tak`:** the new PC arrives the following cycle. The fetch stage never presents an instruction fetched under the old path after `jmp_tak` is seen.
- **Simultaneous `mem_done` and `jmp_tak`:** cache filled, output discarded, IDLE next.
- **Reset during WAIT:** IDLE next edge, `mem_req`=0, no fill.

## Test plan

- **Cold miss:** reset, `pc_in`=0x0, memory returns 0x00000013 after 3 cycles.
  - `mem_req`=1 with `mem_addr`=0x0; `stall_req` high for 4 cycles.
  - Then `if_valid`=1, `if_inst`=0x13, `if_pc`=0x0.
- **Hit stream:** after filling 0x0/0x4/0x8, re-present them on consecutive cycles.
  - `if_valid`=1 on three consecutive cycles, `stall_req`=0, `mem_req` never rises.
- **Jump in WAIT:** miss on 0x100, `jmp_tak` two cycles later, then `mem_done`.
  - `if_valid` stays 0; line 0x100 is filled (next fetch of 0x100 hits with no `mem_req`).
- **Stall on fill:** `stall_in`=1 in the `mem_done` cycle, released one cycle later with `pc_in` held.
  - Instruction presented as a hit with no second `mem_req`.
- **Aliasing:** IDX_W=6; fetch 0x0, then 0x100 (same index), then 0x0.
  - Three misses, third `mem_addr`=0x0.
- **Reset mid-miss:** assert `rst_in` during WAIT.
  - Next cycle: `mem_req`=0, `if_valid`=0; refetch of the same PC misses.
